// File: rtl/pkt_param_pkg.sv
// pkt_param_pkg: register map indices, reset values, parameter record and commit states for packet_param_bank
package pkt_param_pkg;
  localparam logic [3:0] R_MAC_HI = 4'h1, R_MAC_LO = 4'h2, R_IP = 4'h3, R_MMAC_HI = 4'h4,
    R_MMAC_LO = 4'h5, R_MIP = 4'h6, R_SRC = 4'h7, R_DST = 4'h8, R_LEN = 4'h9, R_START = 4'hA,
    R_STATUS = 4'hE, R_COMMIT = 4'hF;
  localparam logic [23:0] MCAST_OUI = 24'h01005E;
  localparam logic [47:0] RST_MAC = 48'h002236EC0401;
  localparam logic [31:0] RST_IP = 32'h0A000014, RST_MIP = 32'hE04DEC06;
  localparam logic [15:0] RST_SRC = 16'h5152, RST_DST = 16'h2179;
  typedef enum logic {IDLE, PEND} commit_st_t;
  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
    logic [47:0] mcast_mac;
    logic [31:0] mcast_ip;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [15:0] start;
  } params_t;
  function automatic logic [47:0] mcast_mac_of(input logic [31:0] ip);
    return {MCAST_OUI, 1'b0, ip[22:0]};
  endfunction
  function automatic params_t reset_params(input logic [3:0] c, input logic [15:0] len);
    params_t p;
    p.mac = RST_MAC + 48'(c);
    p.ip = RST_IP + 32'(c);
    p.mcast_ip = RST_MIP + 32'(c);
    p.mcast_mac = mcast_mac_of(p.mcast_ip);
    p.src = RST_SRC;
    p.dst = RST_DST;
    p.len = len;
    p.start = '0;
    return p;
  endfunction
endpackage

// File: rtl/packet_param_bank_if.sv
// packet_param_bank_if: eb register bus (addr, write data/strobe, read strobe, read data/valid)
interface packet_param_bank_if;
  logic [7:0] i_eb_addr;
  logic [31:0] i_eb_wr_data;
  logic i_eb_wr;
  logic i_eb_rd;
  logic [31:0] o_eb_rd_data;
  logic o_eb_rd_valid;
  modport slave (input i_eb_addr, i_eb_wr_data, i_eb_wr, i_eb_rd, output o_eb_rd_data, o_eb_rd_valid);
  modport master (output i_eb_addr, i_eb_wr_data, i_eb_wr, i_eb_rd, input o_eb_rd_data, o_eb_rd_valid);
endinterface

// File: rtl/pkt_param_chan.sv
// pkt_param_chan: one channel's shadow/active registers and packet-boundary commit FSM (wr is pre-decoded for this channel)
module pkt_param_chan import pkt_param_pkg::*; #(
  parameter logic [3:0] CH = 4'd0,
  parameter logic [15:0] MIN_LEN = 16'd64,
  parameter logic [15:0] MAX_LEN = 16'd2000,
  parameter bit AUTO_MCAST = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic wr,
  input logic [3:0] reg_idx,
  input logic [31:0] wr_data,
  input logic busy,
  output logic [31:0] rd_val,
  output params_t act,
  output logic pend,
  output logic done
);
  commit_st_t st;
  params_t shd, shd_nxt, cmt;
  logic [15:0] len_in;
  assign len_in = wr_data[15:0] < MIN_LEN ? MIN_LEN : wr_data[15:0] > MAX_LEN ? MAX_LEN : wr_data[15:0];
  assign pend = st == PEND;
  always_comb begin
    shd_nxt = shd;
    if (wr)
      case (reg_idx)
        R_MAC_HI: shd_nxt.mac[47:16] = wr_data;
        R_MAC_LO: shd_nxt.mac[15:0] = wr_data[15:0];
        R_IP: shd_nxt.ip = wr_data;
        R_MMAC_HI: shd_nxt.mcast_mac[47:16] = AUTO_MCAST ? shd.mcast_mac[47:16] : wr_data;
        R_MMAC_LO: shd_nxt.mcast_mac[15:0] = AUTO_MCAST ? shd.mcast_mac[15:0] : wr_data[15:0];
        R_MIP: shd_nxt.mcast_ip = wr_data;
        R_SRC: shd_nxt.src = wr_data[15:0];
        R_DST: shd_nxt.dst = wr_data[15:0];
        R_LEN: shd_nxt.len = len_in;
        R_START: shd_nxt.start = wr_data[15:0];
        default: ;
      endcase
    cmt = shd_nxt;
    cmt.mcast_mac = AUTO_MCAST ? mcast_mac_of(shd_nxt.mcast_ip) : shd_nxt.mcast_mac;
  end
  always_comb begin
    rd_val = '0;
    case (reg_idx)
      R_MAC_HI: rd_val = shd.mac[47:16];
      R_MAC_LO: rd_val = {16'd0, shd.mac[15:0]};
      R_IP: rd_val = shd.ip;
      R_MMAC_HI: rd_val = shd.mcast_mac[47:16];
      R_MMAC_LO: rd_val = {16'd0, shd.mcast_mac[15:0]};
      R_MIP: rd_val = shd.mcast_ip;
      R_SRC: rd_val = {16'd0, shd.src};
      R_DST: rd_val = {16'd0, shd.dst};
      R_LEN: rd_val = {16'd0, shd.len};
      R_START: rd_val = {16'd0, shd.start};
      R_STATUS: rd_val = {30'd0, busy, pend};
      default: ;
    endcase
  end
  // commit copies shd_nxt so a shadow write landing on the commit cycle is included
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      done <= 1'b0;
      shd <= reset_params(CH, MAX_LEN);
      act <= reset_params(CH, MAX_LEN);
    end else begin
      shd <= shd_nxt;
      done <= 1'b0;
      if (st == PEND && !busy) begin
        act <= cmt;
        done <= 1'b1;
        st <= IDLE;
      end else if (st == IDLE && wr && reg_idx == R_COMMIT)
        st <= PEND;
    end
endmodule

// File: rtl/packet_param_bank.sv
// packet_param_bank: multi-channel UDP/IP parameter bank; eb bus decode, per-channel banks, registered readback
module packet_param_bank import pkt_param_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter logic [15:0] MIN_LEN = 16'd64,
  parameter logic [15:0] MAX_LEN = 16'd2000,
  parameter bit AUTO_MCAST = 1'b1
) (
  input logic clk,
  input logic rst,
  packet_param_bank_if.slave eb,
  input logic [NUM_CH-1:0] i_pkt_busy,
  output logic [NUM_CH-1:0] o_commit_pend,
  output logic [NUM_CH-1:0] o_commit_done,
  output logic [48*NUM_CH-1:0] o_self_mac,
  output logic [32*NUM_CH-1:0] o_self_ip,
  output logic [48*NUM_CH-1:0] o_mcast_mac,
  output logic [32*NUM_CH-1:0] o_mcast_ip,
  output logic [16*NUM_CH-1:0] o_udp_src_port,
  output logic [16*NUM_CH-1:0] o_udp_dst_port,
  output logic [16*NUM_CH-1:0] o_udp_pkt_len,
  output logic [16*NUM_CH-1:0] o_udp_start_addr
);
  logic [31:0] ch_rd [NUM_CH];
  logic [31:0] rd_mux;
  logic rd_go;
  assign rd_go = eb.i_eb_rd && !eb.i_eb_wr;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    params_t act;
    logic [31:0] rd_val;
    pkt_param_chan #(.CH(4'(c)), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .AUTO_MCAST(AUTO_MCAST)) u_chan (
      .clk(clk),
      .rst(rst),
      .wr(eb.i_eb_wr && eb.i_eb_addr[7:4] == 4'(c)),
      .reg_idx(eb.i_eb_addr[3:0]),
      .wr_data(eb.i_eb_wr_data),
      .busy(i_pkt_busy[c]),
      .rd_val(rd_val),
      .act(act),
      .pend(o_commit_pend[c]),
      .done(o_commit_done[c])
    );
    assign ch_rd[c] = rd_val;
    assign o_self_mac[c*48 +: 48] = act.mac;
    assign o_self_ip[c*32 +: 32] = act.ip;
    assign o_mcast_mac[c*48 +: 48] = act.mcast_mac;
    assign o_mcast_ip[c*32 +: 32] = act.mcast_ip;
    assign o_udp_src_port[c*16 +: 16] = act.src;
    assign o_udp_dst_port[c*16 +: 16] = act.dst;
    assign o_udp_pkt_len[c*16 +: 16] = act.len;
    assign o_udp_start_addr[c*16 +: 16] = act.start;
  end
  // channels at or above NUM_CH match nothing and read back as zero
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (eb.i_eb_addr[7:4] == 4'(c)) rd_mux = ch_rd[c];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      eb.o_eb_rd_valid <= 1'b0;
      eb.o_eb_rd_data <= '0;
    end else begin
      eb.o_eb_rd_valid <= rd_go;
      if (rd_go) eb.o_eb_rd_data <= rd_mux;
    end
endmodule

// File: tb/tb_packet_param_bank.sv
// tb_packet_param_bank: randomized + directed check of packet_param_bank against a register-map model
module tb_packet_param_bank;
  logic clk = 0, rst = 0;
  logic [7:0] a = 0;
  logic [31:0] wd = 0;
  logic wr = 0, rd = 0;
  logic [3:0] busy = 0;
  logic [3:0] pend, done;
  logic [191:0] self_mac, mcast_mac;
  logic [127:0] self_ip, mcast_ip;
  logic [63:0] src, dst, len, start;
  int n_chk = 0, n_fail = 0;
  logic [31:0] sr [4][16];
  logic [31:0] ar [4][16];
  logic [3:0] m_pend, m_done;
  logic m_rdv;
  logic [31:0] m_rdd;
  packet_param_bank_if eb();
  assign eb.i_eb_addr = a;
  assign eb.i_eb_wr_data = wd;
  assign eb.i_eb_wr = wr;
  assign eb.i_eb_rd = rd;
  packet_param_bank dut (
    .clk(clk), .rst(rst), .eb(eb), .i_pkt_busy(busy),
    .o_commit_pend(pend), .o_commit_done(done),
    .o_self_mac(self_mac), .o_self_ip(self_ip), .o_mcast_mac(mcast_mac), .o_mcast_ip(mcast_ip),
    .o_udp_src_port(src), .o_udp_dst_port(dst), .o_udp_pkt_len(len), .o_udp_start_addr(start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic m_reset();
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 16; r++) sr[c][r] = 0;
      sr[c][1] = 32'h002236EC;
      sr[c][2] = 32'h00000401 + c;
      sr[c][3] = 32'h0A000014 + c;
      sr[c][4] = 32'h01005E4D;
      sr[c][5] = 32'h0000EC06 + c;
      sr[c][6] = 32'hE04DEC06 + c;
      sr[c][7] = 32'h5152;
      sr[c][8] = 32'h2179;
      sr[c][9] = 2000;
      ar[c] = sr[c];
    end
    m_pend = 0;
    m_done = 0;
    m_rdv = 0;
    m_rdd = 0;
  endtask
  task automatic m_step();
    logic [3:0] ch, r, com;
    logic [15:0] v;
    ch = a[7:4];
    r = a[3:0];
    m_rdv = rd && !wr;
    if (m_rdv) m_rdd = ch >= 4 ? 32'h0 : r == 14 ? {30'd0, busy[ch[1:0]], m_pend[ch[1:0]]} : sr[ch[1:0]][r];
    com = m_pend & ~busy;
    if (wr && ch < 4 && r >= 1 && r <= 10 && r != 4 && r != 5) begin
      v = wd[15:0];
      if (r == 9) v = v < 64 ? 16'd64 : v > 2000 ? 16'd2000 : v;
      sr[ch[1:0]][r] = (r == 2 || r >= 7) ? {16'd0, v} : wd;
    end
    for (int c = 0; c < 4; c++)
      if (com[c]) begin
        ar[c] = sr[c];
        m_pend[c] = 0;
      end else if (wr && ch == 4'(c) && r == 15) m_pend[c] = 1;
    m_done = com;
  endtask
  task automatic cmp_all();
    chk("rd_valid", eb.o_eb_rd_valid, m_rdv);
    if (m_rdv) chk("rd_data", eb.o_eb_rd_data, m_rdd);
    chk("pend", pend, m_pend);
    chk("done", done, m_done);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("mac%0d", c), self_mac[c*48 +: 48], {ar[c][1], ar[c][2][15:0]});
      chk($sformatf("ip%0d", c), self_ip[c*32 +: 32], ar[c][3]);
      chk($sformatf("mcast_ip%0d", c), mcast_ip[c*32 +: 32], ar[c][6]);
      chk($sformatf("mcast_mac%0d", c), mcast_mac[c*48 +: 48], {24'h01005E, 1'b0, ar[c][6][22:0]});
      chk($sformatf("src%0d", c), src[c*16 +: 16], ar[c][7][15:0]);
      chk($sformatf("dst%0d", c), dst[c*16 +: 16], ar[c][8][15:0]);
      chk($sformatf("len%0d", c), len[c*16 +: 16], ar[c][9][15:0]);
      chk($sformatf("start%0d", c), start[c*16 +: 16], ar[c][10][15:0]);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    if (rst) m_reset();
    else m_step();
    #1;
    cmp_all();
  endtask
  task automatic drive(input logic w, input logic r, input logic [7:0] ad, input logic [31:0] d);
    wr = w;
    rd = r;
    a = ad;
    wd = d;
  endtask
  initial begin
    m_reset();
    #1 rst = 1;
    #1;
    chk("rst_rd_valid", eb.o_eb_rd_valid, 1'b0);
    chk("rst_rd_data", eb.o_eb_rd_data, 32'h0);
    chk("rst_pend", pend, 4'h0);
    chk("rst_done", done, 4'h0);
    cyc();
    cyc();
    rst = 0;
    drive(0, 1, 8'h13, 0); cyc();
    drive(0, 0, 8'h00, 0);
    chk("rd_ch1_ip_valid", eb.o_eb_rd_valid, 1'b1);
    chk("rd_ch1_ip", eb.o_eb_rd_data, 32'h0A000015);
    chk("act_ch1_ip", self_ip[63:32], 32'h0A000015);
    cyc();
    chk("rd_valid_drop", eb.o_eb_rd_valid, 1'b0);
    drive(1, 0, 8'h09, 10); cyc();
    drive(0, 1, 8'h09, 0); cyc();
    chk("len_clamp_lo", eb.o_eb_rd_data, 32'd64);
    chk("len_act_hold", len[15:0], 16'd2000);
    drive(1, 0, 8'h09, 5000); cyc();
    drive(0, 1, 8'h09, 0); cyc();
    chk("len_clamp_hi", eb.o_eb_rd_data, 32'd2000);
    busy = 4'b0100;
    drive(1, 0, 8'h23, 32'hC0A801CA); cyc();
    drive(1, 0, 8'h2F, 0); cyc();
    drive(0, 0, 8'h00, 0); cyc();
    chk("pend2_busy", pend[2], 1'b1);
    chk("ip2_unchanged", self_ip[95:64], 32'h0A000016);
    busy = 0; cyc();
    chk("done2", done[2], 1'b1);
    chk("ip2_commit", self_ip[95:64], 32'hC0A801CA);
    chk("pend2_clr", pend[2], 1'b0);
    cyc();
    chk("done2_pulse", done[2], 1'b0);
    busy = 4'b0010;
    drive(1, 0, 8'h1F, 0); cyc();
    busy = 0;
    drive(1, 0, 8'h16, 32'hE0010203); cyc();
    drive(0, 0, 8'h00, 0);
    chk("done1_fwd", done[1], 1'b1);
    chk("mip1_fwd", mcast_ip[63:32], 32'hE0010203);
    chk("mmac1_fwd", mcast_mac[95:48], 48'h01005E010203);
    drive(1, 0, 8'h53, 32'hDEADBEEF); cyc();
    drive(0, 1, 8'h53, 0); cyc();
    drive(0, 0, 8'h00, 0);
    chk("ch5_rd_valid", eb.o_eb_rd_valid, 1'b1);
    chk("ch5_rd_data", eb.o_eb_rd_data, 32'h0);
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            {4'($urandom_range(0, 5)), 4'($urandom)}, $urandom_range(0, 1) ? $urandom : $urandom_range(0, 2100));
      busy = 4'($urandom & $urandom);
      cyc();
    end
    busy = 4'b1000;
    drive(1, 0, 8'h33, 32'h12345678); cyc();
    drive(1, 0, 8'h3F, 0); cyc();
    drive(0, 1, 8'h33, 0); cyc();
    drive(0, 0, 8'h00, 0);
    chk("pend3_pre_rst", pend[3], 1'b1);
    chk("rd3_pre_rst", eb.o_eb_rd_data, 32'h12345678);
    drive(0, 1, 8'h13, 0);
    #2 rst = 1;
    #1;
    m_reset();
    cmp_all();
    chk("pend_mid_rst", pend, 4'h0);
    chk("rdv_mid_rst", eb.o_eb_rd_valid, 1'b0);
    chk("ip3_mid_rst", self_ip[127:96], 32'h0A000017);
    cyc();
    rst = 0;
    busy = 0;
    drive(0, 1, 8'h33, 0); cyc();
    drive(0, 0, 8'h00, 0);
    chk("rd3_after_rst", eb.o_eb_rd_data, 32'h0A000017);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
